// File: rtl/counter_pkg.sv
// Shared constants and helpers for the synchronous modulo counter.
package counter_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    // Highest reachable count: modulus-1, or all ones of `width` bits when modulus is 0.
    function automatic logic [WIDTH_MAX-1:0] cnt_last(input logic [WIDTH_MAX-1:0] modulus,
                                                      input int unsigned width);
        logic [WIDTH_MAX-1:0] full;
        full = (width >= WIDTH_MAX) ? '1 : ((WIDTH_MAX'(1) << width) - WIDTH_MAX'(1));
        return (modulus != '0) ? (modulus - WIDTH_MAX'(1)) : full;
    endfunction

endpackage

// File: rtl/cnt_prescaler.sv
// Enable-gated prescaler: asserts tick once every prescale+1 enabled cycles.
module cnt_prescaler #(
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] ps_q, ps_d;

    assign tick = (ps_q == prescale);

    always_comb begin
        ps_d = ps_q;
        if (clr) begin
            ps_d = '0;
        end else if (en) begin
            ps_d = tick ? '0 : ps_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

endmodule

// File: rtl/sync_mod_counter.sv
// Synchronous modulo-N up/down counter with load, terminal count and wrap pulse.
// Optional prescaler compiled in with SYNC_MOD_COUNTER_PRESCALE_EN.
module sync_mod_counter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      modulus,
`ifdef SYNC_MOD_COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  wrap
);

    import counter_pkg::*;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || PRESCALE_W < 1) begin : g_bad_params
        $error("sync_mod_counter: illegal WIDTH or PRESCALE_W");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] last;
    logic             tick;
    logic             step;

    assign last = WIDTH'(cnt_last(WIDTH_MAX'(modulus), WIDTH));

`ifdef SYNC_MOD_COUNTER_PRESCALE_EN
    cnt_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign step = en && tick;

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = (load_val > last) ? last : load_val;
        end else if (step) begin
            if (up_dn == CNT_UP) begin
                if (count_q >= last) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = last;
                    wrap_d  = 1'b1;
                end else if (count_q > last) begin
                    // Modulus was lowered under us: clamp without signalling a wrap.
                    count_d = last;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = (up_dn == CNT_UP) ? (count_q == last) : (count_q == '0);

endmodule

// File: doc/sync_mod_counter.md
# sync_mod_counter

Fully synchronous, parametrised modulo-N up/down counter. It replaces ripple-clocked T-flip-flop chains in new designs. All state is clocked by the single `clk`; no derived clocks are generated. The block provides programmable modulus, direction, parallel load, count enable, terminal-count and wrap indications. It is used as a timebase and event counter throughout the datapath.

## Interface
- `WIDTH`, 8: counter width in bits; legal range 2..32.
- `PRESCALE_W`, 4: prescaler width; only used when the prescaler is compiled in.
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  count enable; the counter holds while low.
- `up_dn`  in  1  direction: 1 = up, 0 = down; sampled every cycle.
- `load`  in  1  parallel load strobe.
- `load_val`  in  WIDTH  value to load.
- `modulus`  in  WIDTH  count range is 0..modulus-1; 0 means the full 2^WIDTH range.
- `prescale`  in  PRESCALE_W  step every prescale+1 enabled cycles; port exists only with the macro.
- `count`  out  WIDTH  current count, registered.
- `tc`  out  1  terminal count, combinational: up and count==last, or down and count==0.
- `wrap`  out  1  registered one-cycle pulse, high in the cycle `count` shows the wrapped value.

## Operation
- Definition: `last` = modulus-1 when modulus!=0, else all ones.
- `step` = `en` && `tick`. Without the prescaler, `tick` is 1.
- Priority per edge: `rst` > `load` > `step` > hold.
- Reset: `count`=0, `wrap`=0, prescaler count=0.
- Load: `count` = min(load_val, last); `wrap`=0; prescaler count cleared. Load is honoured even when `en`=0.
- Step up: if count >= last, then `count`=0 and `wrap`=1; otherwise count+1.
- Step down: if count==0, then `count`=last and `wrap`=1; if count > last (modulus lowered at runtime), then `count`=last with no wrap; otherwise count-1.
- `wrap` is 0 in every cycle that is not a wrapping step.
- modulus==1: `count` stays 0 and `wrap` pulses on every step.
- Changing `modulus` or `up_dn` mid-run takes effect on the next step; no state is lost.
- All arithmetic is WIDTH-bit unsigned. Full-range mode wraps naturally at 2^WIDTH.

## Timing
- Step latency: `count` updates on the edge where `step`=1 and is visible the following cycle.
- `tc` follows `count` and `up_dn` combinationally, in the same cycle.
- `wrap` is aligned with the new `count` value.
- `rst` asserted mid-run clears all state on that edge, regardless of `load` or `en`.

## Configuration
- Macro: `SYNC_MOD_COUNTER_PRESCALE_EN`.
- Defined:
  - A PRESCALE_W-bit prescaler advances only while `en`=1.
  - `tick` is asserted when the prescaler equals `prescale`; the prescaler then returns to 0.
  - `prescale`=0 gives a step on every enabled cycle.
  - `load` and `rst` clear the prescaler.
  - `en`=0 freezes the prescaler.
- Undefined: no prescaler logic and no `prescale` port; `tick` is 1.

## Structure
- Package `counter_pkg`:
  - direction constants `CNT_UP`=1 and `CNT_DN`=0;
  - function `cnt_last(modulus)` returning `last`;
  - WIDTH bounds constants.
- Sub-module `cnt_prescaler` (clk, rst, en, clr, prescale, tick) is instantiated only under the macro.

## Test plan
- Reset check: drive rst=1 for 2 cycles with en=1. Then `count`=0, `wrap`=0, and `tc`=0 with up_dn=1.
- Up wrap: WIDTH=8, modulus=10, up_dn=1, en=1 for 12 steps. Expected sequence 0..9,0,1; `tc`=1 at 9; `wrap` pulses once, aligned with count 0.
- Down wrap and clamp:
  - modulus=10, up_dn=0 from 0: next count 9 with `wrap`=1.
  - Set count 200 via modulus=0, then set modulus=10: next step gives 9 with `wrap`=0.
- Load priority and clamp:
  - load=1 with load_val=250, modulus=100, en=1: `count`=99, no step that cycle.
  - rst=1 together with load=1: `count`=0.
- Full range: modulus=0, up from 254. Expected 255 with `tc`=1, then 0 with `wrap`=1. Hold with en=0 for 5 cycles: `count` unchanged.
- Prescaler (macro defined): prescale=3, en=1, modulus=0. Expect a step every 4th cycle. Deassert en for 2 cycles mid-period: the period is extended by exactly 2.
